// File: rtl/muldiv_if.sv
// Start/ready/valid handshake bundle between the execute stage and the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      mdcode;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            kill;
  logic            ready;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, mdcode, op1, op2, kill,
    input  ready, busy, result_valid, result
  );

  modport slave (
    input  start, mdcode, op1, op2, kill,
    output ready, busy, result_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, retiring BITS_PER_CYCLE bits per cycle, sign-fixed at the end.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave md
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         code_q, code_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN:0]      rem_q, rem_d;

  logic [2*XLEN-1:0]  m_acc, prod;
  logic [XLEN:0]      m_sum, d_rem, d_sh, d_diff;
  logic [XLEN-1:0]    d_quo, quo_fix, rem_fix, fin_val;

  // One iteration of both datapaths; code_q selects which one is kept.
  always_comb begin
    m_acc = acc_q;
    m_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      m_sum = {1'b0, m_acc[2*XLEN-1:XLEN]} + (m_acc[0] ? {1'b0, b_q} : '0);
      m_acc = {m_sum, m_acc[XLEN-1:1]};
    end
    d_quo  = acc_q[XLEN-1:0];
    d_rem  = rem_q;
    d_sh   = '0;
    d_diff = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      d_sh   = {d_rem[XLEN-1:0], d_quo[XLEN-1]};
      d_quo  = {d_quo[XLEN-2:0], 1'b0};
      d_diff = d_sh - {1'b0, b_q};
      if (!d_diff[XLEN]) begin
        d_rem    = d_diff;
        d_quo[0] = 1'b1;
      end else begin
        d_rem = d_sh;
      end
    end
    prod    = neg_q ? -m_acc : m_acc;
    quo_fix = neg_q ? -d_quo : d_quo;
    rem_fix = sa_q ? -d_rem[XLEN-1:0] : d_rem[XLEN-1:0];
    if (code_q[2])           fin_val = code_q[1] ? rem_fix : quo_fix;
    else if (code_q == 3'd0) fin_val = prod[XLEN-1:0];
    else                     fin_val = prod[2*XLEN-1:XLEN];
  end

  logic            accept, sa_in, sb_in, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    accept = md.start && !md.kill && (state_q != CALC);
    sa_in  = (md.mdcode == 3'd1) || (md.mdcode == 3'd2) ||
             (md.mdcode == 3'd4) || (md.mdcode == 3'd6);
    sb_in  = (md.mdcode == 3'd1) || (md.mdcode == 3'd4) || (md.mdcode == 3'd6);
    a_neg  = sa_in && md.op1[XLEN-1];
    b_neg  = sb_in && md.op2[XLEN-1];
    a_mag  = a_neg ? -md.op1 : md.op1;
    b_mag  = b_neg ? -md.op2 : md.op2;

    case (state_q)
      CALC: begin
        if (md.kill) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          acc_d = code_q[2] ? {acc_q[2*XLEN-1:XLEN], d_quo} : m_acc;
          rem_d = d_rem;
          if (cnt_q == CW'(1)) begin
            state_d  = FIN;
            result_d = fin_val;
          end
        end
      end
      default: begin
        if (accept) begin
          code_d = md.mdcode;
          neg_d  = a_neg ^ b_neg;
          sa_d   = a_neg;
          b_d    = b_mag;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          rem_d  = '0;
          if (md.mdcode[2] && (md.op2 == '0)) begin
            state_d  = FIN;
            result_d = md.mdcode[1] ? md.op1 : '1;
          end else if (md.mdcode[2] && !md.mdcode[0] && (md.op2 == '1) &&
                       (md.op1 == {1'b1, {(XLEN-1){1'b0}}})) begin
            state_d  = FIN;
            result_d = md.mdcode[1] ? '0 : md.op1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(N);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign md.ready        = (state_q != CALC);
  assign md.busy         = (state_q == CALC);
  assign md.result_valid = (state_q == FIN);
  assign md.result       = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle alu in the execute stage.
- Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU using an iterative shift-add / restoring-divide datapath.
- Parametrised in operand width and bits retired per cycle.
- Uses a start/ready/valid handshake; the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; must be even, >= 8.
- BITS_PER_CYCLE, 1, multiplier/quotient bits processed per iteration cycle; must divide XLEN (1, 2, 4 legal).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request; accepted only when ready=1.
- mdcode  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1  in  XLEN  rs1 value: multiplicand or dividend.
- op2  in  XLEN  rs2 value: multiplier or divisor.
- kill  in  1  abort the current operation (pipeline flush).
- ready  out  1  unit can accept start this cycle.
- busy  out  1  operation in progress; the stage stalls on this.
- result_valid  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  product half, quotient or remainder.

Behaviour:
- Reset: when rst_n=0 at an edge, go to IDLE; ready=1, busy=0, result_valid=0, result=0, counter=0. Reset overrides start and kill and aborts any operation in flight.
- States and outputs:
  - IDLE: ready=1, busy=0.
  - CALC: ready=0, busy=1.
  - FIN: ready=1, busy=0, result_valid=1.
- Let N = XLEN/BITS_PER_CYCLE, and call the cycle in which start&ready is sampled "cycle k".
- Start acceptance (IDLE or FIN with start=1):
  - Latch mdcode and op1, op2.
  - Latch operand signs: signed for MULH/DIV/REM; op1 signed and op2 unsigned for MULHSU; unsigned otherwise.
  - Convert operands to magnitudes and load counter=N.
  - Next state is CALC, or FIN for the special cases below.
- CALC:
  - Each cycle processes BITS_PER_CYCLE bits and decrements counter.
  - When counter reaches 1, go to FIN.
  - result_valid therefore asserts in cycle k+N+1.
- FIN:
  - Apply sign correction. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Select the output: low XLEN bits for MUL, high XLEN bits for MULH/MULHSU/MULHU.
  - result is registered and holds until the next FIN or reset.
  - Without a new start, go to IDLE. With start, accept back-to-back and go to CALC.
- Special cases (no CALC; result_valid in cycle k+1):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1 = most-negative value, op2 = all-ones, DIV/REM): DIV returns op1, REM returns 0.
- kill:
  - In CALC: go to IDLE at the next edge with no result_valid; result is unchanged.
  - In FIN: result_valid still asserts that cycle, but any start in the same cycle is ignored.
  - In IDLE: no effect.
  - kill has priority over start.
- start while ready=0 is ignored (no queuing). Operand inputs are don't-care outside the accept cycle.
- Arithmetic:
  - Internal accumulator is 2*XLEN bits. Divide uses an XLEN+1-bit partial remainder.
  - No exceptions are raised. All wrap-around follows two's-complement XLEN truncation.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB; valid in cycle k+33 with defaults; busy high for exactly 32 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF in cycle k+1. REMU 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Back-to-back: MUL 3×5 then, with start held in FIN, DIVU 15/5 -> results 15 then 3; ready never drops between them except during CALC.
- Abort and reset:
  - kill at cycle k+10 of DIV -> no result_valid, ready=1 next cycle, result keeps its old value.
  - rst_n=0 mid-CALC -> all outputs at reset values next cycle.
  - Repeat all cases with BITS_PER_CYCLE=4 and check latency N=8.
